// File: rtl/hpm_cntrs_pkg.sv
// Shared types and constants for the hardware performance counter block.
// Slot numbering, write-select encoding and evtsel sizing live here.
package hpm_cntrs_pkg;

    localparam int CNTR_CYCLE   = 0;
    localparam int CNTR_TIME    = 1;
    localparam int CNTR_INSTRET = 2;

    localparam int NUM_CNTRS_DEF = 8;
    localparam int CNTR_AW_DEF   = $clog2(NUM_CNTRS_DEF);

    typedef logic [CNTR_AW_DEF-1:0] cntr_t;

    typedef enum logic [1:0] {
        WSEL_CNTR    = 2'd0,
        WSEL_EVTSEL  = 2'd1,
        WSEL_INHIBIT = 2'd2,
        WSEL_NONE    = 2'd3
    } cntr_wsel_t;

    function automatic int evtsel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpm_cntr_slice.sv
// One counter: half-word write merge, gated +1 increment, sticky overflow.
// A write to either half suppresses that edge's increment.
module hpm_cntr_slice
    import hpm_cntrs_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CNTR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  inhibit,
    input  logic                  wr_lo,
    input  logic                  wr_hi,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  ovf_clr,
    output logic [CNTR_WIDTH-1:0] cnt,
    output logic                  ovf
);

    localparam int HW = CNTR_WIDTH - XLEN;

    logic inc;
    logic wrap;

    assign inc  = en & ~inhibit & ~wr_lo & ~wr_hi;
    assign wrap = inc & (&cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr_lo) begin
                cnt[XLEN-1:0] <= wr_data;
            end else if (wr_hi) begin
                cnt[CNTR_WIDTH-1:XLEN] <= wr_data[HW-1:0];
            end else if (inc) begin
                cnt <= cnt + CNTR_WIDTH'(1);
            end
            // a wrap on the same edge as a clear keeps the flag set
            ovf <= wrap | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: rtl/hpm_cntrs.sv
// Cycle/time/instret plus event-selectable HPM counters with split reads.
// Optional SUROV_CNTR_SNAPSHOT_EN: atomic high-half snapshot on low reads.
module hpm_cntrs
    import hpm_cntrs_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CNTR_WIDTH = 64,
    parameter int NUM_CNTRS  = 8,
    parameter int NUM_EVT    = 8,
    parameter int CNTR_AW    = $clog2(NUM_CNTRS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_retire,
    input  logic [NUM_EVT-1:0]   evt,
    input  logic [CNTR_AW-1:0]   rd_addr,
    input  logic                 rd_hi,
    output logic [XLEN-1:0]      rd_data,
    input  logic                 wr_en,
    input  logic [1:0]           wr_sel,
    input  logic [CNTR_AW-1:0]   wr_addr,
    input  logic                 wr_hi,
    input  logic [XLEN-1:0]      wr_data,
    output logic [NUM_CNTRS-1:0] ovf,
    input  logic [NUM_CNTRS-1:0] ovf_clr
);

    localparam int EW = evtsel_w(NUM_EVT);
    localparam int HW = CNTR_WIDTH - XLEN;
    localparam logic [NUM_CNTRS-1:0] INH_MASK =
        ~(NUM_CNTRS'(1) << CNTR_TIME);

    logic [CNTR_WIDTH-1:0] cnt [NUM_CNTRS];
    logic [NUM_CNTRS-1:0]  inhibit;
    cntr_wsel_t            wsel;
    logic                  wr_ok;
    logic                  wr_cntr;

    assign wsel    = cntr_wsel_t'(wr_sel);
    assign wr_ok   = wr_en && (int'(wr_addr) < NUM_CNTRS);
    assign wr_cntr = wr_ok && (wsel == WSEL_CNTR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit <= '0;
        end else if (wr_ok && wsel == WSEL_INHIBIT) begin
            inhibit <= wr_data[NUM_CNTRS-1:0] & INH_MASK;
        end
    end

    for (genvar k = 0; k < NUM_CNTRS; k++) begin : g_slot
        if (k == CNTR_TIME) begin : g_time
            assign cnt[k] = '0;
            assign ovf[k] = 1'b0;
        end else begin : g_cnt
            logic en;
            logic wr_lo_k;
            logic wr_hi_k;
            logic hit;

            assign hit     = wr_cntr && (wr_addr == CNTR_AW'(k));
            assign wr_lo_k = hit && !wr_hi;
            assign wr_hi_k = hit && wr_hi;

            if (k == CNTR_CYCLE) begin : g_cyc
                assign en = 1'b1;
            end else if (k == CNTR_INSTRET) begin : g_ret
                assign en = instr_retire;
            end else begin : g_hpm
                logic [EW-1:0] sel_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sel_q <= '0;
                    end else if (wr_ok && wsel == WSEL_EVTSEL &&
                                 wr_addr == CNTR_AW'(k)) begin
                        sel_q <= wr_data[EW-1:0];
                    end
                end

                // selects past NUM_EVT match nothing and count nothing
                always_comb begin
                    en = 1'b0;
                    for (int j = 0; j < NUM_EVT; j++) begin
                        if (sel_q == EW'(j)) en = evt[j];
                    end
                end
            end

            hpm_cntr_slice #(
                .XLEN       (XLEN),
                .CNTR_WIDTH (CNTR_WIDTH)
            ) u_slice (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .inhibit (inhibit[k]),
                .wr_lo   (wr_lo_k),
                .wr_hi   (wr_hi_k),
                .wr_data (wr_data),
                .ovf_clr (ovf_clr[k]),
                .cnt     (cnt[k]),
                .ovf     (ovf[k])
            );
        end
    end

    logic [CNTR_WIDTH-1:0] live;
    logic [HW-1:0]         hi_live;
    logic [HW-1:0]         hi_sel;

    always_comb begin
        live = '0;
        for (int k = 0; k < NUM_CNTRS; k++) begin
            if (rd_addr == CNTR_AW'(k)) live = cnt[k];
        end
    end

    assign hi_live = live[CNTR_WIDTH-1:XLEN];

`ifdef SUROV_CNTR_SNAPSHOT_EN
    logic [HW-1:0]      snap_hi;
    logic [CNTR_AW-1:0] snap_tag;
    logic               snap_vld;
    logic               rd_ok;

    assign rd_ok = int'(rd_addr) < NUM_CNTRS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_hi  <= '0;
            snap_tag <= '0;
            snap_vld <= 1'b0;
        end else if (!rd_hi) begin
            snap_hi  <= hi_live;
            snap_tag <= rd_addr;
            snap_vld <= rd_ok && !(wr_cntr && wr_addr == rd_addr);
        end else if (rd_addr != snap_tag ||
                     (wr_cntr && wr_addr == snap_tag)) begin
            snap_vld <= 1'b0;
        end
    end

    assign hi_sel = (snap_vld && snap_tag == rd_addr) ? snap_hi : hi_live;
`else
    assign hi_sel = hi_live;
`endif

    assign rd_data = rd_hi ? XLEN'(hi_sel) : live[XLEN-1:0];

endmodule

// File: tb/tb_hpm_cntrs.sv
// Directed bench for hpm_cntrs with hand-computed expectations.
// Expected snapshot result follows SUROV_CNTR_SNAPSHOT_EN.
module tb_hpm_cntrs;

    localparam int XLEN = 32;
    localparam int CW   = 64;
    localparam int NC   = 6;
    localparam int NE   = 8;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_retire;
    logic [NE-1:0]   evt;
    logic [AW-1:0]   rd_addr;
    logic            rd_hi;
    logic [XLEN-1:0] rd_data;
    logic            wr_en;
    logic [1:0]      wr_sel;
    logic [AW-1:0]   wr_addr;
    logic            wr_hi;
    logic [XLEN-1:0] wr_data;
    logic [NC-1:0]   ovf;
    logic [NC-1:0]   ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    hpm_cntrs #(
        .XLEN       (XLEN),
        .CNTR_WIDTH (CW),
        .NUM_CNTRS  (NC),
        .NUM_EVT    (NE),
        .CNTR_AW    (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_retire (instr_retire),
        .evt          (evt),
        .rd_addr      (rd_addr),
        .rd_hi        (rd_hi),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_hi        (wr_hi),
        .wr_data      (wr_data),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, input bit hi, output logic [31:0] v);
        rd_addr = AW'(a);
        rd_hi   = hi;
        #1;
        v = rd_data;
    endtask

    task automatic wr(input int sel, input int a, input bit hi,
                      input logic [31:0] d);
        wr_en   = 1'b1;
        wr_sel  = 2'(sel);
        wr_addr = AW'(a);
        wr_hi   = hi;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    logic [31:0] v;
    logic [31:0] exp_snap;

    initial begin
        rst = 1'b1; instr_retire = 1'b0; evt = '0;
        rd_addr = '0; rd_hi = 1'b0; wr_en = 1'b0; wr_sel = '0;
        wr_addr = '0; wr_hi = 1'b0; wr_data = '0; ovf_clr = '0;
        tick(); tick();
        rst = 1'b0;
        rd(0, 0, v); check("reset_cycle", v, 32'h0);
        check("reset_ovf", 32'(ovf), 32'h0);

        wr(0, 0, 0, 32'h1234);
        rd(0, 0, v); check("cycle_wr", v, 32'h1234);
        rst = 1'b1;
        #1;
        check("async_rst_rd", rd_data, 32'h0);
        check("async_rst_ovf", 32'(ovf), 32'h0);
        rd(2, 0, v); check("async_rst_instret", v, 32'h0);
        rst = 1'b0;
        rd_addr = '0;
        tick();
        rd(0, 0, v); check("cycle_after_rst", v, 32'h1);

        wr(0, 0, 0, 32'hFFFF_FFFF);
        wr(0, 0, 1, 32'hFFFF_FFFF);
        rd(0, 1, v); check("cycle_ones_hi", v, 32'hFFFF_FFFF);
        check("ovf_before_wrap", 32'(ovf), 32'h0);
        tick();
        rd(0, 0, v); check("cycle_wrap_lo", v, 32'h0);
        rd(0, 1, v); check("cycle_wrap_hi", v, 32'h0);
        check("ovf_wrap", 32'(ovf), 32'h1);

        wr(0, 0, 0, 32'hFFFF_FFFF);
        wr(0, 0, 1, 32'hFFFF_FFFF);
        ovf_clr = 6'h01;
        tick();
        ovf_clr = '0;
        check("ovf_set_wins", 32'(ovf), 32'h1);
        ovf_clr = 6'h01;
        tick();
        ovf_clr = '0;
        check("ovf_clr", 32'(ovf), 32'h0);
        wr(2, 0, 0, 32'h1);
        tick();
        rd(0, 0, v); check("cycle_inhibit", v, 32'h2);

        wr(1, 3, 0, 32'h2);
        evt = 8'b0000_0111;
        repeat (3) tick();
        evt = 8'b0000_0100;
        repeat (2) tick();
        evt = 8'b0000_0011;
        repeat (2) tick();
        evt = '0;
        rd(3, 0, v); check("hpm3_count", v, 32'h5);
        wr(2, 0, 0, 32'h9);
        evt = 8'b0000_0100;
        repeat (4) tick();
        evt = '0;
        rd(3, 0, v); check("hpm3_inhibit", v, 32'h5);
        wr(2, 0, 0, 32'h1);

        evt = 8'b0000_0100;
        wr(0, 3, 0, 32'h10);
        evt = '0;
        rd(3, 0, v); check("hpm3_wr_vs_evt", v, 32'h10);
        rd(3, 1, v); check("hpm3_hi_kept", v, 32'h0);

        wr(0, 6, 0, 32'hDEAD);
        wr(2, 6, 0, 32'h0);
        wr(3, 3, 0, 32'h55);
        rd(3, 0, v); check("oob_wr_hpm3", v, 32'h10);
        rd(0, 0, v); check("oob_wr_inh", v, 32'h2);
        rd(6, 0, v); check("oob_rd6", v, 32'h0);
        rd(7, 1, v); check("oob_rd7", v, 32'h0);

        wr(0, 2, 0, 32'hFFFF_FFFF);
        wr(0, 2, 1, 32'h1);
        rd(2, 0, v); check("instret_lo", v, 32'hFFFF_FFFF);
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
`ifdef SUROV_CNTR_SNAPSHOT_EN
        exp_snap = 32'h1;
`else
        exp_snap = 32'h2;
`endif
        rd(2, 1, v); check("instret_snap_hi", v, exp_snap);
        rd(2, 0, v); check("instret_new_lo", v, 32'h0);
        rd_addr = 3'd3; rd_hi = 1'b0;
        tick();
        rd(2, 1, v); check("instret_live_hi", v, 32'h2);

        wr(1, 1, 0, 32'h5);
        wr(0, 1, 0, 32'h77);
        wr(0, 1, 1, 32'h77);
        wr(1, 0, 0, 32'h5);
        rd(1, 0, v); check("time_lo", v, 32'h0);
        rd(1, 1, v); check("time_hi", v, 32'h0);
        rd(0, 0, v); check("cycle_evtsel_wr", v, 32'h2);
        check("ovf_none", 32'(ovf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
